cmul_seq_core: RTL

- Multi-cycle signed complex multiplier: (ar + j·ai) × (br + j·bi).
- Uses one shared W×W signed multiplier and one (2W+1)-bit two's-complement add/sub datapath. Subtraction is a + ~b + 1, carry-in = 1.
- Sits directly upstream of the wide ripple-carry adder stage. It produces the real/imag partial-product sums that the stage consumes.
- Valid/ready handshake on both sides.

---
 rtl/cmul_seq_core.sv | 112 +++++++++++
 1 files changed

// File: rtl/cmul_seq_core.sv
// rtl/cmul_seq_core.sv - multi-cycle signed complex multiplier, one shared multiplier and add/sub datapath
module cmul_seq_core #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   ar,
    input  logic [W-1:0]   ai,
    input  logic [W-1:0]   br,
    input  logic [W-1:0]   bi,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W:0]   re_out,
    output logic [2*W:0]   im_out,
    output logic           busy
);
    localparam int PW = 2 * W;
    localparam int RW = 2 * W + 1;

    typedef enum logic [2:0] {IDLE, S_AC, S_BD, S_AD, S_BC, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    ar_q, ai_q, br_q, bi_q;
    logic [W-1:0]    ar_d, ai_d, br_d, bi_d;
    logic [RW-1:0]   acc_q, acc_d;
    logic [RW-1:0]   re_q, re_d;
    logic [RW-1:0]   im_q, im_d;

    logic [W-1:0]    mul_a, mul_b;
    logic [PW-1:0]   prod;
    logic [RW-1:0]   prod_ext;
    logic [RW-1:0]   sum;
    logic            sub;
    logic            accept;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign re_out    = re_q;
    assign im_out    = im_q;
    assign accept    = in_valid && in_ready;

    // Operand select depends only on state, so the multiplier only ever sees latched operands.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            S_AC:    begin mul_a = ar_q; mul_b = br_q; end
            S_BD:    begin mul_a = ai_q; mul_b = bi_q; end
            S_AD:    begin mul_a = ar_q; mul_b = bi_q; end
            S_BC:    begin mul_a = ai_q; mul_b = br_q; end
            default: begin mul_a = '0;   mul_b = '0;   end
        endcase
    end

    assign prod     = $signed({{W{mul_a[W-1]}}, mul_a}) * $signed({{W{mul_b[W-1]}}, mul_b});
    assign prod_ext = {prod[PW-1], prod};
    assign sub      = (state_q == S_BD);
    assign sum      = acc_q + (sub ? ~prod_ext : prod_ext) + {{(RW-1){1'b0}}, sub};

    always_comb begin
        state_d = state_q;
        ar_d    = ar_q;
        ai_d    = ai_q;
        br_d    = br_q;
        bi_d    = bi_q;
        acc_d   = acc_q;
        re_d    = re_q;
        im_d    = im_q;
        case (state_q)
            IDLE: state_d = IDLE;
            S_AC: begin acc_d = prod_ext; state_d = S_BD; end
            S_BD: begin re_d  = sum;      state_d = S_AD; end
            S_AD: begin acc_d = prod_ext; state_d = S_BC; end
            S_BC: begin im_d  = sum;      state_d = DONE; end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A DONE handshake with new operands chains straight into the next operation.
        if (accept) begin
            ar_d    = ar;
            ai_d    = ai;
            br_d    = br;
            bi_d    = bi;
            state_d = S_AC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ar_q    <= '0;
            ai_q    <= '0;
            br_q    <= '0;
            bi_q    <= '0;
            acc_q   <= '0;
            re_q    <= '0;
            im_q    <= '0;
        end else begin
            state_q <= state_d;
            ar_q    <= ar_d;
            ai_q    <= ai_d;
            br_q    <= br_d;
            bi_q    <= bi_d;
            acc_q   <= acc_d;
            re_q    <= re_d;
            im_q    <= im_d;
        end
    end
endmodule
